// File: rtl/fifo_flags.sv
// Synchronous FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow errors.
module fifo_flags #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   af_thr,
    input  logic [ADDR_WIDTH:0]   ae_thr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic empty_w;
    logic full_w;
    logic push_acc;
    logic pop_acc;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);

    // A full FIFO still takes a push when the same edge frees a slot.
    assign pop_acc  = pop && !empty_w;
    assign push_acc = push && (!full_w || pop_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem_q[rd_ptr_q];
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (push && full_w && !pop) begin
            ovf_d = 1'b1;
        end
        if (pop && empty_w) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage needs no reset: clearing the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (push_acc && !reset) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out      = data_out_q;
    assign count         = count_q;
    assign empty         = empty_w;
    assign full          = full_w;
    assign almost_full   = (count_q >= af_thr);
    assign almost_empty  = (count_q <= ae_thr);
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;

endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 12: entry width; the destination field sits at bits [9:8].
REQ-002 Parameter ADDR_WIDTH, default 3: depth = 2**ADDR_WIDTH entries (8).
REQ-003 Port clk  input  1: the block's single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port push  input  1: write request; data_in is written on this edge when accepted.
REQ-006 Port pop  input  1: read request.
REQ-007 Port data_in  input  DATA_WIDTH: write data.
REQ-008 Port af_thr  input  ADDR_WIDTH+1: almost-full threshold, in entries.
REQ-009 Port ae_thr  input  ADDR_WIDTH+1: almost-empty threshold, in entries.
REQ-010 Port data_out  output  DATA_WIDTH: registered read data.
REQ-011 Port count  output  ADDR_WIDTH+1: current occupancy, 0..DEPTH.
REQ-012 Port empty, full, almost_full, almost_empty  output  1 each: occupancy flags.
REQ-013 Port overflow_err, underflow_err  output  1 each: sticky error flags.

Function
REQ-014 Storage SHALL be a DEPTH-entry circular buffer with ADDR_WIDTH-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-015 A push SHALL be accepted when push=1 and either full=0, or full=1 with pop=1 accepted on the same edge.
REQ-016 An accepted push SHALL store data_in at wr_ptr and advance wr_ptr by one.
REQ-017 A pop SHALL be accepted when pop=1 and empty=0.
REQ-018 An accepted pop SHALL load data_out with the entry at rd_ptr on that edge, so data_out is valid in the cycle after pop is asserted, and SHALL advance rd_ptr.
REQ-019 data_out SHALL hold its value on every edge without an accepted pop.
REQ-020 count update rules:
- +1 on a push-only edge.
- -1 on a pop-only edge.
- unchanged when both push and pop are accepted, or when neither is.
REQ-021 Flag derivation, combinational from registered count:
- empty = (count==0)
- full = (count==DEPTH)
- almost_full = (count >= af_thr)
- almost_empty = (count <= ae_thr)
REQ-022 Push while full with no pop: data is dropped; pointers and count are unchanged; overflow_err is set on that edge.
REQ-023 Pop while empty: ignored; data_out is unchanged; underflow_err is set on that edge.
REQ-024 Push and pop together while empty: the push is accepted, the pop is rejected per REQ-023, and count becomes 1.
REQ-025 Push and pop together while full: both are accepted; count stays DEPTH; no error is raised.
REQ-026 overflow_err and underflow_err SHALL remain 1 until reset.
REQ-027 Thresholds are live inputs: a threshold change takes effect on the flags in the same cycle, with no edge required.

Reset
REQ-028 Assertion of reset SHALL immediately, without waiting for clk, clear:
- wr_ptr and rd_ptr
- count and data_out (both to 0)
- overflow_err and underflow_err
REQ-029 During and after reset, flags follow count: empty=1, full=0, almost_empty=1 (for ae_thr>=0), almost_full=0 (for af_thr>0).
REQ-030 Reset asserted mid-transfer SHALL discard all stored entries; the request in flight on the reset edge has no effect.
REQ-031 The first push after reset deassertion SHALL be accepted normally.

Verification
REQ-032 Scenario basic order:
- Stimulus: reset, then push 0x100, 0x201, 0x302 on consecutive edges, then pop three times.
- Required: data_out = 0x100, 0x201, 0x302 in the cycles after each pop; count returns 0; empty=1.
REQ-033 Scenario fill and overflow:
- Stimulus: af_thr=6; push 9 entries with no pop.
- Required: almost_full rises when count=6; full=1 at count=8; the 9th push is dropped; overflow_err=1 and stays 1.
REQ-034 Scenario underflow:
- Stimulus: reset, then pop.
- Required: underflow_err=1, data_out=0, count=0.
- Stimulus: then push 0x0AA and pop.
- Required: data_out=0x0AA.
REQ-035 Scenario wrap-around:
- Stimulus: push and pop 20 entries with values 0..19, holding occupancy at 1-3.
- Required: every value is returned in order across pointer wrap; no error flag is set.
REQ-036 Scenario simultaneous push/pop:
- When full: count stays 8, the oldest entry is output, the new entry is stored last, and no error is raised.
- When empty: count becomes 1 and underflow_err=1.
REQ-037 Scenario asynchronous reset:
- Stimulus: fill with 5 entries, then assert reset between clock edges.
- Required: count=0, empty=1, data_out=0, and both error flags=0 before the next clk edge.
